// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One-word lines; loads stall through a refill, stores always go through to memory.
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     cpu_byte_op,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte_op,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
  localparam int SETS      = 1 << SET_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  // state_q is the observable FSM state for checkers.
  state_t state_q;
  state_t state_d;

  logic [SETS-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  logic [SET_WIDTH-1:0]  index;
  logic [TAG_WIDTH-1:0]  tag;
  logic [1:0]            offset;
  logic [4:0]            lane_shift;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_data;
  logic [7:0]            line_byte;
  logic [DATA_WIDTH-1:0] merged_data;
  logic                  load_hit;
  logic                  load_miss;
  logic                  fill_en;
  logic                  store_upd;

  assign index      = cpu_addr[SET_WIDTH+1:2];
  assign tag        = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign offset     = cpu_addr[1:0];
  // Big-endian lanes: offset 0 is the most significant byte.
  assign lane_shift = {~offset, 3'b000};
  assign line_data  = data_mem[index];
  assign hit        = valid_q[index] && (tag_mem[index] == tag);
  assign line_byte  = 8'(line_data >> lane_shift);

  assign merged_data = cpu_byte_op
    ? ((line_data & ~(DATA_WIDTH'(8'hFF) << lane_shift)) |
       (DATA_WIDTH'(cpu_wdata[7:0]) << lane_shift))
    : cpu_wdata;

  assign load_hit  = (state_q == IDLE) && cpu_req && !cpu_we && hit;
  assign load_miss = (state_q == IDLE) && cpu_req && !cpu_we && !hit;
  assign fill_en   = (state_q == REFILL) && mem_ack;
  assign store_upd = (state_q == WRITE) && mem_ack && hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_byte_op = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = cpu_byte_op ? DATA_WIDTH'(line_byte) : line_data;
          end else begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_byte_op = cpu_byte_op;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        cpu_ready   = mem_ack;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= mem_rdata;
    end else if (store_upd) begin
      data_mem[index] <= merged_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (load_miss && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic checked against
// an array-based cache/memory model and a cycle-count expectation per access.
module tb_dcache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte_op;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  // Reference model: cache lines, backing memory, counters.
  bit          mv [64];
  logic [23:0] mt [64];
  logic [31:0] md [64];
  logic [31:0] mem_model [logic [29:0]];
  int          m_hits;
  int          m_misses;
  logic [31:0] last_rd;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte_op(cpu_byte_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte_op(mem_byte_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (!mem_model.exists(addr[31:2])) mem_model[addr[31:2]] = $urandom;
    return mem_model[addr[31:2]];
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] word, input logic [1:0] off, input bit bop);
    if (!bop) return word;
    return (word >> ((3 - int'(off)) * 8)) & 32'hFF;
  endfunction

  function automatic logic [31:0] put(input logic [31:0] word, input logic [1:0] off,
                                      input bit bop, input logic [31:0] wd);
    int sh;
    if (!bop) return wd;
    sh = (3 - int'(off)) * 8;
    return (word & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // Called and returns at posedge+1. Acts as CPU and as memory with latency lat.
  task automatic access(input bit we, input bit bop, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int idx, cyc, reqc, exp_cyc, exp_req;
    logic [23:0] tg;
    bit hit, done;
    logic [31:0] rd;
    idx = int'(addr[7:2]);
    tg  = addr[31:8];
    hit = mv[idx] && (mt[idx] == tg);
    cpu_req = 1'b1; cpu_we = we; cpu_byte_op = bop; cpu_addr = addr; cpu_wdata = wdata;
    if (we) begin
      exp_cyc = lat + 1; exp_req = lat;
    end else begin
      exp_cyc = hit ? 1 : lat + 2; exp_req = hit ? 0 : lat;
    end
    cyc = 0; reqc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      if (mem_req) begin
        reqc++;
        mem_ack = (reqc == lat);
        mem_rdata = $urandom;
        if (mem_ack && !we) begin
          rd = mem_rd(addr);
          mem_rdata = rd;
          mv[idx] = 1'b1; mt[idx] = tg; md[idx] = rd;
        end
        if (mem_ack && we) begin
          mem_model[addr[31:2]] = put(mem_rd(addr), addr[1:0], bop, wdata);
          if (hit) md[idx] = put(md[idx], addr[1:0], bop, wdata);
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, we});
        chk("mem_byte_op", {31'h0, mem_byte_op}, {31'h0, we & bop});
        chk("mem_addr", mem_addr, we ? addr : {addr[31:2], 2'b00});
        if (we) chk("mem_wdata", mem_wdata, wdata);
      end
      if (cpu_ready) begin
        done = 1'b1;
        if (!we) begin
          last_rd = cpu_rdata;
          chk("cpu_rdata", cpu_rdata, pick(md[idx], addr[1:0], bop));
        end
      end
      @(posedge clk);
    end
    #1;
    mem_ack = 1'b0;
    chk("access_cycles", cyc, exp_cyc);
    chk("mem_req_cycles", reqc, exp_req);
    if (!we) begin
      m_hits++;
      if (!hit) m_misses++;
    end
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte_op = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    clear_model();
    #12;
    chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_misses", miss_count, 32'h0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Word refill with 3-cycle memory.
    mem_model[30'h0000_4000] = 32'hDEADBEEF;
    access(0, 0, 32'h0001_0000, 0, 3);
    chk("first_load_data", last_rd, 32'hDEADBEEF);
    chk("first_load_misses", miss_count, 32'd1);
    chk("first_load_hits", hit_count, 32'd1);

    // Byte loads, all hits.
    for (int i = 0; i < 4; i++) access(0, 1, 32'h0001_0000 + i, 0, 2);
    chk("byte3_data", last_rd, 32'h0000_00EF);

    access(1, 1, 32'h0001_0002, 32'h1234_5655, 2);
    access(0, 0, 32'h0001_0000, 0, 2);
    chk("merged_word", last_rd, 32'hDEAD55EF);

    // Store miss does not allocate.
    access(1, 0, 32'h0001_1000, 32'hCAFEF00D, 1);
    access(0, 0, 32'h0001_0000, 0, 2);
    chk("store_miss_no_alloc", last_rd, 32'hDEAD55EF);
    access(0, 0, 32'h0001_1000, 0, 2);
    chk("store_miss_mem_data", last_rd, 32'hCAFEF00D);

    // Conflict sequence: three refills on index 0.
    begin
      int m0;
      m0 = m_misses;
      access(0, 0, 32'h0001_0000, 0, 1);
      access(0, 0, 32'h0001_0100, 0, 4);
      access(0, 0, 32'h0001_0000, 0, 2);
      chk("conflict_misses", miss_count, 32'(m0 + 3));
    end

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 250; n++) begin
      a = {24'h000100 + 24'($urandom_range(0, 2)), 4'h0, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      access($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(1, 4));
    end

    // Reset in the middle of a refill.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte_op = 1'b0; cpu_addr = 32'h0002_0040;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("refill_before_rst", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rst_mid_hits", hit_count, 32'h0);
    chk("rst_mid_misses", miss_count, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    access(0, 0, 32'h0002_0040, 0, 2);
    chk("post_rst_miss", miss_count, 32'd1);
    access(0, 0, 32'h0001_0000, 0, 1);
    chk("post_rst_valid_cleared", miss_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
